// File: rtl/rr_index_arbiter_if.sv
// rr_index_arbiter_if: request/grant bundle between requesters, arbiter and 4-to-16 decode stage.
//   req[15:0]    requester request lines (level)
//   out_ready    decode stage accepts A
//   A[3:0]       granted index, registered
//   out_valid    A holds a valid grant
//   ack[15:0]    one-cycle one-hot acknowledge to the served requester
//   count[7:0]   completed handshakes, modulo 256
interface rr_index_arbiter_if;
  logic [15:0] req;
  logic        out_ready;
  logic [3:0]  A;
  logic        out_valid;
  logic [15:0] ack;
  logic [7:0]  count;
  modport master (input req, out_ready, output A, out_valid, ack, count);
  modport slave (output req, out_ready, input A, out_valid, ack, count);
endinterface

// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter: 16-way arbiter emitting a registered binary grant index with valid/ready handshake.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rr_index_arbiter_if.master (req/out_ready in, A/out_valid/ack/count out)
//   PRIO_FIXED  0 = round-robin after last served index, 1 = lowest eligible index wins
module rr_index_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input logic clk,
  input logic rst,
  rr_index_arbiter_if.master bus
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t      state;
  logic [3:0]  ptr;
  logic [3:0]  rr_idx;
  logic [3:0]  fx_idx;
  logic [3:0]  win;
  logic [15:0] eligible;
  // the requester being acknowledged this cycle is excluded from the next grant
  assign eligible = bus.req & ~bus.ack;
  // descending loops leave the highest-priority hit as the final assignment;
  // offset 16 wraps to ptr itself, so the last served index ranks last
  always_comb begin
    rr_idx = 4'd0;
    fx_idx = 4'd0;
    for (int i = 16; i >= 1; i--)
      if (eligible[4'(ptr + 4'(i))]) rr_idx = 4'(ptr + 4'(i));
    for (int i = 15; i >= 0; i--)
      if (eligible[i]) fx_idx = 4'(i);
  end
  assign win = (PRIO_FIXED != 0) ? fx_idx : rr_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 4'hF;
      bus.A         <= 4'd0;
      bus.out_valid <= 1'b0;
      bus.ack       <= 16'h0;
      bus.count     <= 8'd0;
    end else begin
      bus.ack <= 16'h0;
      if (state == IDLE) begin
        if (|eligible) begin
          bus.A         <= win;
          bus.out_valid <= 1'b1;
          state         <= OFFER;
        end
      end else if (bus.out_ready) begin
        ptr           <= bus.A;
        bus.ack       <= 16'd1 << bus.A;
        bus.count     <= bus.count + 8'd1;
        bus.out_valid <= 1'b0;
        state         <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb_rr_index_arbiter: scoreboard bench for round-robin and fixed-priority arbiter instances.
module tb_rr_index_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rr_index_arbiter_if if0();
  rr_index_arbiter_if if1();
  rr_index_arbiter #(.PRIO_FIXED(0)) dut_rr (.clk(clk), .rst(rst), .bus(if0.master));
  rr_index_arbiter #(.PRIO_FIXED(1)) dut_fx (.clk(clk), .rst(rst), .bus(if1.master));
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [7:0] exp_cnt = 8'd0;
  logic [3:0] last_a = 4'd0;
  logic [3:0] e;
  bit ack_pending = 1'b0;
  // scoreboard monitor for the round-robin instance
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 8'd0;
      ack_pending = 1'b0;
    end else begin
      checks++;
      if (ack_pending) begin
        if (if0.ack !== (16'd1 << last_a) || if0.count !== exp_cnt) begin
          errors++;
          $display("FAIL ack_count: ack=%h count=%0d, expected ack=%h count=%0d", if0.ack, if0.count, 16'd1 << last_a, exp_cnt);
        end
      end else if (if0.ack !== 16'h0) begin
        errors++;
        $display("FAIL spurious_ack: ack=%h, expected 0000", if0.ack);
      end
      ack_pending = 1'b0;
      if (if0.out_valid && if0.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: A=%0d, expected no grant", if0.A);
        end else begin
          e = exp_q.pop_front();
          if (if0.A !== e) begin
            errors++;
            $display("FAIL grant_index: A=%0d, expected %0d", if0.A, e);
          end
        end
        last_a = if0.A;
        exp_cnt++;
        ack_pending = 1'b1;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int budget, output bit ok);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
    ok = (exp_q.size() == 0);
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    if0.req = 16'h0; if0.out_ready = 1'b0;
    if1.req = 16'h0; if1.out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    exp_q.delete();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    if0.req = 16'hFFFF; if0.out_ready = 1'b1;
    if1.req = 16'hFFFF; if1.out_ready = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({if0.out_valid, if0.A, if0.ack, if0.count} !== 29'h0) begin
      errors++;
      $display("FAIL reset_rr: ov=%b A=%0d ack=%h count=%0d, expected all 0", if0.out_valid, if0.A, if0.ack, if0.count);
    end
    checks++;
    if ({if1.out_valid, if1.A, if1.ack, if1.count} !== 29'h0) begin
      errors++;
      $display("FAIL reset_fx: ov=%b A=%0d ack=%h count=%0d, expected all 0", if1.out_valid, if1.A, if1.ack, if1.count);
    end
    rst = 1'b0;
    if0.req = 16'h0; if0.out_ready = 1'b0;
    if1.req = 16'h0; if1.out_ready = 1'b0;
    cyc();
  endtask
  task automatic test_single();
    if0.req = 16'h0001; if0.out_ready = 1'b1;
    exp_q.push_back(4'd0);
    cyc();
    checks++;
    if (if0.out_valid !== 1'b1 || if0.A !== 4'd0) begin
      errors++;
      $display("FAIL single_grant: ov=%b A=%0d, expected ov=1 A=0", if0.out_valid, if0.A);
    end
    if0.req = 16'h0;
    cyc();
    checks++;
    if (if0.ack !== 16'h0001 || if0.count !== 8'd1 || if0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: ack=%h count=%0d ov=%b, expected ack=0001 count=1 ov=0", if0.ack, if0.count, if0.out_valid);
    end
    cyc();
  endtask
  task automatic test_round_robin();
    bit ok;
    apply_reset();
    if0.req = 16'h8001; if0.out_ready = 1'b1;
    exp_q.push_back(4'd0); exp_q.push_back(4'd15); exp_q.push_back(4'd0); exp_q.push_back(4'd15);
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (if0.out_valid !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL rr_alternate[%0d]: ov=%b, expected %b", i, if0.out_valid, (i % 2) == 0);
      end
    end
    if0.req = 16'h0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_grants_left: %0d pending, expected 0", exp_q.size());
    end
    cyc();
    if0.req = 16'h8003;
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd15);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd15);
    drain(40, ok);
    if0.req = 16'h0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_wrap_timeout: %0d grants missing, expected 0", exp_q.size());
    end
    cyc();
  endtask
  task automatic test_fixed();
    logic [3:0] fx_exp [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
    int k = 0;
    apply_reset();
    if1.req = 16'h8003; if1.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (if1.out_valid && k < 4) begin
        checks++;
        if (if1.A !== fx_exp[k]) begin
          errors++;
          $display("FAIL fixed_grant[%0d]: A=%0d, expected %0d", k, if1.A, fx_exp[k]);
        end
        k++;
      end
    end
    if1.req = 16'h0;
    checks++;
    if (k != 4 || if1.count !== 8'd4) begin
      errors++;
      $display("FAIL fixed_count: grants=%0d count=%0d, expected 4 and 4", k, if1.count);
    end
    cyc();
  endtask
  task automatic test_hold();
    if0.req = 16'h0010; if0.out_ready = 1'b0;
    exp_q.push_back(4'd4);
    cyc();
    checks++;
    if (if0.out_valid !== 1'b1 || if0.A !== 4'd4) begin
      errors++;
      $display("FAIL hold_grant: ov=%b A=%0d, expected ov=1 A=4", if0.out_valid, if0.A);
    end
    if0.req = 16'h0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({if0.out_valid, if0.A, if0.ack, if0.count} !== {1'b1, 4'd4, 16'h0, exp_cnt}) begin
        errors++;
        $display("FAIL hold_stable[%0d]: ov=%b A=%0d ack=%h count=%0d, expected ov=1 A=4 ack=0000 count=%0d", i, if0.out_valid, if0.A, if0.ack, if0.count, exp_cnt);
      end
    end
    if0.out_ready = 1'b1;
    cyc();
    checks++;
    if (if0.ack !== 16'h0010) begin
      errors++;
      $display("FAIL hold_ack: ack=%h, expected 0010", if0.ack);
    end
    cyc();
  endtask
  task automatic test_rst_offer();
    bit ok;
    if0.req = 16'h0200; if0.out_ready = 1'b0;
    cyc();
    checks++;
    if (if0.out_valid !== 1'b1 || if0.A !== 4'd9) begin
      errors++;
      $display("FAIL offer9: ov=%b A=%0d, expected ov=1 A=9", if0.out_valid, if0.A);
    end
    rst = 1'b1; if0.out_ready = 1'b1;
    cyc();
    rst = 1'b0; if0.req = 16'h0;
    checks++;
    if ({if0.out_valid, if0.A, if0.ack, if0.count} !== 29'h0) begin
      errors++;
      $display("FAIL rst_offer: ov=%b A=%0d ack=%h count=%0d, expected all 0", if0.out_valid, if0.A, if0.ack, if0.count);
    end
    if0.req = 16'h0006;
    exp_q.push_back(4'd1);
    drain(10, ok);
    if0.req = 16'h0;
    checks++;
    if (!ok || if0.ack !== 16'h0002) begin
      errors++;
      $display("FAIL rst_first_grant: pending=%0d ack=%h, expected 0 and 0002", exp_q.size(), if0.ack);
    end
    cyc();
  endtask
  task automatic test_count_wrap();
    bit ok;
    apply_reset();
    if0.req = 16'h0003; if0.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) exp_q.push_back((i % 2) ? 4'd1 : 4'd0);
    drain(700, ok);
    if0.req = 16'h0;
    checks++;
    if (!ok || if0.count !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap0: pending=%0d count=%0d, expected 0 and 0", exp_q.size(), if0.count);
    end
    exp_q.push_back(4'd0);
    if0.req = 16'h0003;
    drain(10, ok);
    if0.req = 16'h0;
    checks++;
    if (!ok || if0.count !== 8'd1) begin
      errors++;
      $display("FAIL count_wrap1: pending=%0d count=%0d, expected 0 and 1", exp_q.size(), if0.count);
    end
    cyc();
    cyc();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed();
    test_hold();
    test_rst_offer();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
